// File: rtl/edge_window_sequencer.sv
// Raster-to-3x3 window sequencer for the vertical edge detector: two line buffers, a shift
// window, frame position tracking and realignment/border masking of the detector's edge bit.
module edge_window_sequencer #(
  parameter int DATA_W  = 10,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int DET_LAT = 1
) (
  input  logic                  clock,
  input  logic                  iRST_N,
  input  logic                  iValid,
  input  logic                  iSOF,
  input  logic [DATA_W-1:0]     iPixel,
  output logic [9*DATA_W-1:0]   oGrid,
  output logic                  oGridValid,
  input  logic                  iEdge,
  output logic                  oEdge,
  output logic                  oEdgeValid,
  output logic [9:0]            oX,
  output logic [9:0]            oY,
  output logic                  oFrameDone
);

  localparam int         AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        acc_p0;
  logic [9:0]  px_p0, py_p0;

  // Stage p0: accept decision and position of the incoming pixel
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_p0  = iValid && (iSOF || (state_q == ACTIVE));
    px_p0   = iSOF ? 10'd0 : x_q;
    py_p0   = iSOF ? 10'd0 : y_q;
    if (acc_p0) begin
      state_d = ACTIVE;
      if (px_p0 == X_LAST) begin
        x_d = 10'd0;
        if (py_p0 == Y_LAST) begin
          y_d     = 10'd0;
          state_d = IDLE;
        end else begin
          y_d = py_p0 + 10'd1;
        end
      end else begin
        x_d = px_p0 + 10'd1;
        y_d = py_p0;
      end
    end
  end

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [AW-1:0]     addr_p0;
  logic [DATA_W-1:0] col_p0 [3];

  assign addr_p0   = px_p0[AW-1:0];
  assign col_p0[0] = lb1_mem[addr_p0];
  assign col_p0[1] = lb0_mem[addr_p0];
  assign col_p0[2] = iPixel;

  // Line buffers are never reset; stale lines only reach windows that the border mask hides.
  always_ff @(posedge clock) begin
    if (acc_p0) begin
      lb1_mem[addr_p0] <= col_p0[1];
      lb0_mem[addr_p0] <= iPixel;
    end
  end

  // Stage p1: window register, grid valid and result tag
  logic [DATA_W-1:0] win_p1_q [9];
  logic              gv_p1_q, bd_p1_q, last_p1_q;
  logic [9:0]        cx_p1_q, cy_p1_q;

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int k = 0; k < 9; k++) win_p1_q[k] <= '0;
      gv_p1_q   <= 1'b0;
      bd_p1_q   <= 1'b0;
      last_p1_q <= 1'b0;
      cx_p1_q   <= '0;
      cy_p1_q   <= '0;
    end else begin
      gv_p1_q <= acc_p0 && (px_p0 >= 10'd1) && (py_p0 >= 10'd1);
      if (acc_p0) begin
        for (int r = 0; r < 3; r++) begin
          win_p1_q[3*r+2] <= win_p1_q[3*r+1];
          win_p1_q[3*r+1] <= win_p1_q[3*r];
          win_p1_q[3*r]   <= col_p0[r];
        end
        cx_p1_q   <= px_p0 - 10'd1;
        cy_p1_q   <= py_p0 - 10'd1;
        bd_p1_q   <= (px_p0 == 10'd1) || (py_p0 == 10'd1);
        last_p1_q <= (px_p0 == X_LAST) && (py_p0 == Y_LAST);
      end
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_grid
    assign oGrid[k*DATA_W +: DATA_W] = win_p1_q[k];
  end
  assign oGridValid = gv_p1_q;

  // Stage p2: tag delay matching the detector latency; shifts every cycle
  logic       vld_p2_q  [DET_LAT];
  logic       bd_p2_q   [DET_LAT];
  logic       last_p2_q [DET_LAT];
  logic [9:0] cx_p2_q   [DET_LAT];
  logic [9:0] cy_p2_q   [DET_LAT];

  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DET_LAT; i++) begin
        vld_p2_q[i]  <= 1'b0;
        bd_p2_q[i]   <= 1'b0;
        last_p2_q[i] <= 1'b0;
        cx_p2_q[i]   <= '0;
        cy_p2_q[i]   <= '0;
      end
    end else begin
      vld_p2_q[0]  <= gv_p1_q;
      bd_p2_q[0]   <= bd_p1_q;
      last_p2_q[0] <= last_p1_q;
      cx_p2_q[0]   <= cx_p1_q;
      cy_p2_q[0]   <= cy_p1_q;
      for (int i = 1; i < DET_LAT; i++) begin
        vld_p2_q[i]  <= vld_p2_q[i-1];
        bd_p2_q[i]   <= bd_p2_q[i-1];
        last_p2_q[i] <= last_p2_q[i-1];
        cx_p2_q[i]   <= cx_p2_q[i-1];
        cy_p2_q[i]   <= cy_p2_q[i-1];
      end
    end
  end

  // Stage p3: masked edge output aligned with its tag
  always_ff @(posedge clock or negedge iRST_N) begin
    if (!iRST_N) begin
      oEdgeValid <= 1'b0;
      oEdge      <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oFrameDone <= 1'b0;
    end else begin
      oEdgeValid <= vld_p2_q[DET_LAT-1];
      oEdge      <= vld_p2_q[DET_LAT-1] && iEdge && !bd_p2_q[DET_LAT-1];
      oX         <= cx_p2_q[DET_LAT-1];
      oY         <= cy_p2_q[DET_LAT-1];
      oFrameDone <= vld_p2_q[DET_LAT-1] && last_p2_q[DET_LAT-1];
    end
  end

endmodule

// File: tb/tb_edge_window_sequencer.sv
// Scoreboard bench for edge_window_sequencer on an 8x6 frame with a registered |L-R|>380
// detector model closing the loop from oGrid to iEdge.
module tb_edge_window_sequencer;

  localparam int DW  = 10;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int LAT = 1;

  logic            clock = 1'b0;
  logic            iRST_N = 1'b0;
  logic            iValid = 1'b0;
  logic            iSOF = 1'b0;
  logic [DW-1:0]   iPixel = '0;
  logic            iEdge = 1'b0;
  logic [9*DW-1:0] oGrid;
  logic            oGridValid, oEdge, oEdgeValid, oFrameDone;
  logic [9:0]      oX, oY;

  edge_window_sequencer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .DET_LAT(LAT)) dut (
    .clock(clock), .iRST_N(iRST_N), .iValid(iValid), .iSOF(iSOF), .iPixel(iPixel),
    .oGrid(oGrid), .oGridValid(oGridValid), .iEdge(iEdge), .oEdge(oEdge),
    .oEdgeValid(oEdgeValid), .oX(oX), .oY(oY), .oFrameDone(oFrameDone)
  );

  always #5 clock = ~clock;

  // Behavioural detector: left column (c=2) against right column (c=0), one cycle latency.
  function automatic logic det(input logic [9*DW-1:0] g);
    int l, r;
    l = 0;
    r = 0;
    for (int k = 0; k < 3; k++) begin
      r += int'(g[(3*k)*DW +: DW]);
      l += int'(g[(3*k+2)*DW +: DW]);
    end
    return ((l > r) ? (l - r) : (r - l)) > 380;
  endfunction

  always @(posedge clock) iEdge <= det(oGrid);

  typedef struct packed {
    logic       e;
    logic [9:0] x;
    logic [9:0] y;
    logic       d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   gv_cnt = 0;
  int   fd_cnt = 0;
  int   gv0, fd0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (oEdgeValid) begin
      if (sb.size() == 0) begin
        chk($sformatf("unexpected_result(%0d,%0d)", oX, oY), 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("edge(%0d,%0d)", mon_e.x, mon_e.y), int'(oEdge), int'(mon_e.e));
        chk($sformatf("x(%0d,%0d)", mon_e.x, mon_e.y), int'(oX), int'(mon_e.x));
        chk($sformatf("y(%0d,%0d)", mon_e.x, mon_e.y), int'(oY), int'(mon_e.y));
        chk($sformatf("done(%0d,%0d)", mon_e.x, mon_e.y), int'(oFrameDone), int'(mon_e.d));
      end
    end else if (oFrameDone) begin
      chk("done_without_valid", int'(oFrameDone), 0);
    end
    if (oGridValid) gv_cnt++;
    if (oFrameDone) fd_cnt++;
  end

  task automatic send(input int x, input int y, input logic [DW-1:0] pix, input logic sof,
                      input logic exp_edge);
    @(posedge clock);
    #1;
    iValid = 1'b1;
    iSOF   = sof;
    iPixel = pix;
    if (x >= 1 && y >= 1)
      sb.push_back('{e: exp_edge, x: 10'(x - 1), y: 10'(y - 1), d: (x == W-1 && y == H-1)});
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    iValid = 1'b0;
    iSOF   = 1'b1;
    iPixel = 10'h3FF;
  endtask

  task automatic stray(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      iValid = 1'b1;
      iSOF   = 1'b0;
      iPixel = 10'd777;
    end
  endtask

  // step=1: cols 0-3 = 0, cols 4-7 = 1000; edges expected at centre columns 3 and 4, rows >= 1.
  task automatic send_frame(input bit step, input bit gaps, input int n_pix);
    int n;
    n = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (n < n_pix) begin
          send(x, y, step ? ((x >= 4) ? 10'd1000 : 10'd0) : 10'd100, (x == 0 && y == 0),
               step && ((x - 1 == 3) || (x - 1 == 4)) && (y - 1 >= 1));
          if (gaps) idle();
        end
        n++;
      end
    end
  endtask

  task automatic drain();
    repeat (6) idle();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grid"}, int'(|oGrid), 0);
    chk({tag, "_gridvalid"}, int'(oGridValid), 0);
    chk({tag, "_edge"}, int'(oEdge), 0);
    chk({tag, "_edgevalid"}, int'(oEdgeValid), 0);
    chk({tag, "_xy"}, int'({oX, oY}), 0);
    chk({tag, "_framedone"}, int'(oFrameDone), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_zero("reset");
    @(posedge clock);
    #1;
    iRST_N = 1'b1;

    // Stray pixels after reset are ignored, then a constant frame
    gv0 = gv_cnt;
    stray(5);
    repeat (4) idle();
    chk("stray_gridvalid", gv_cnt - gv0, 0);
    gv0 = gv_cnt;
    fd0 = fd_cnt;
    send_frame(1'b0, 1'b0, W*H);
    drain();
    chk("const_gv_count", gv_cnt - gv0, 35);
    chk("const_done_count", fd_cnt - fd0, 1);

    // Step frame, continuous
    gv0 = gv_cnt;
    fd0 = fd_cnt;
    send_frame(1'b1, 1'b0, W*H);
    drain();
    chk("step_gv_count", gv_cnt - gv0, 35);
    chk("step_done_count", fd_cnt - fd0, 1);

    // Step frame with iValid every other cycle
    gv0 = gv_cnt;
    fd0 = fd_cnt;
    send_frame(1'b1, 1'b1, W*H);
    drain();
    chk("gap_gv_count", gv_cnt - gv0, 35);
    chk("gap_done_count", fd_cnt - fd0, 1);

    // Resync: constant frame cut after (4,3), new step frame starts at what would be (5,3)
    gv0 = gv_cnt;
    fd0 = fd_cnt;
    send_frame(1'b0, 1'b0, 3*W + 5);
    send_frame(1'b1, 1'b0, W*H);
    drain();
    chk("resync_gv_count", gv_cnt - gv0, 18 + 35);
    chk("resync_done_count", fd_cnt - fd0, 1);

    // Reset mid-frame with results still in flight
    send_frame(1'b0, 1'b0, 20);
    @(posedge clock);
    #1;
    iRST_N = 1'b0;
    iValid = 1'b0;
    iSOF   = 1'b0;
    sb.delete();
    @(negedge clock);
    check_zero("midreset");
    repeat (2) @(posedge clock);
    #1;
    iRST_N = 1'b1;
    gv0 = gv_cnt;
    fd0 = fd_cnt;
    stray(4);
    drain();
    chk("post_reset_gridvalid", gv_cnt - gv0, 0);
    send_frame(1'b1, 1'b0, W*H);
    drain();
    chk("post_reset_gv_count", gv_cnt - gv0, 35);
    chk("post_reset_done_count", fd_cnt - fd0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
